// File: rtl/pcg256_stream_out.sv
// Output stage for the 256-bit PCG generator.
// Captures generator words into a small FIFO, streams each word as OUT_W-bit
// slices (LSB slice first) over valid/ready, and runs a repetition health
// check on capture candidates. Words that arrive while the FIFO is full are
// counted in a saturating overflow counter.
module pcg256_stream_out #(
    parameter int OUT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [255:0]            rnd_in,
    input  logic                    rnd_valid,
    output logic [OUT_W-1:0]        dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             ovf_cnt,
    output logic                    rep_fail
);

    localparam int N  = 256 / OUT_W;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [255:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [IW-1:0] idx;
    logic [255:0]  prev_word;
    logic          prev_valid;
    logic [255:0]  head;

    logic full;
    logic xfer;
    logic last_slice;
    logic pop;
    logic rep_hit;
    logic push;
    logic drop;

    // Handshake decode; full is taken from the pre-pop level, so a word
    // arriving on the same edge as a final-slice pop of a full FIFO is dropped.
    always_comb begin
        full       = (fifo_level == (AW+1)'(DEPTH));
        dout_valid = (fifo_level != '0);
        head       = mem[rd_ptr];
        dout       = head[idx*OUT_W +: OUT_W];
        xfer       = dout_valid && dout_ready;
        last_slice = (idx == IW'(N-1));
        pop        = xfer && last_slice;
        rep_hit    = rnd_valid && prev_valid && (rnd_in == prev_word);
        push       = rnd_valid && !rep_hit && !full;
        drop       = rnd_valid && !rep_hit && full;
    end

    // Word storage; contents are meaningless outside the occupied window,
    // so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rnd_in;
        end
    end

    // FIFO pointers, occupancy and slice index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            idx        <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + (AW+1)'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - (AW+1)'(1);
            end
            if (xfer) begin
                idx <= last_slice ? '0 : idx + IW'(1);
            end
        end
    end

    // Health check and overflow accounting. prev_word tracks the last word
    // actually pushed; dropped and rejected words leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_word  <= '0;
            prev_valid <= 1'b0;
            rep_fail   <= 1'b0;
            ovf_cnt    <= '0;
        end else begin
            if (rep_hit) begin
                rep_fail <= 1'b1;
            end
            if (drop && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
            if (push) begin
                prev_word  <= rnd_in;
                prev_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcg256_stream_out.sv
// Bench for pcg256_stream_out: directed scenarios followed by random traffic.
// A reference model pushes expected slices into a queue on every accepted
// word; a negedge monitor pops and compares on every DUT transfer.
module tb_pcg256_stream_out;

    localparam int OUT_W = 32;
    localparam int DEPTH = 4;
    localparam int N     = 256 / OUT_W;

    logic               clk;
    logic               rst;
    logic [255:0]       rnd_in;
    logic               rnd_valid;
    logic [OUT_W-1:0]   dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [2:0]         fifo_level;
    logic [15:0]        ovf_cnt;
    logic               rep_fail;

    int total = 0;
    int bad   = 0;

    pcg256_stream_out #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_level (fifo_level),
        .ovf_cnt    (ovf_cnt),
        .rep_fail   (rep_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: pending slices across all stored words.
    logic [OUT_W-1:0] exp_q[$];
    int               m_slices;
    logic [255:0]     m_prev;
    bit               m_prev_valid;
    int               m_ovf;
    bit               m_rep;
    bit               m_full;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rnd_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Reference model: word-level FIFO behaviour from the rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_slices     = 0;
            m_prev       = '0;
            m_prev_valid = 0;
            m_ovf        = 0;
            m_rep        = 0;
            exp_q.delete();
        end else begin
            m_full = (((m_slices + N - 1) / N) == DEPTH);
            if (m_slices > 0 && dout_ready) m_slices--;
            if (rnd_valid) begin
                if (m_prev_valid && rnd_in == m_prev) begin
                    m_rep = 1;
                end else if (m_full) begin
                    if (m_ovf != 65535) m_ovf++;
                end else begin
                    m_slices += N;
                    for (int k = 0; k < N; k++) exp_q.push_back(rnd_in[k*OUT_W +: OUT_W]);
                    m_prev       = rnd_in;
                    m_prev_valid = 1;
                end
            end
        end
    end

    // Monitor: status against model, data against scoreboard on each transfer.
    always @(negedge clk) begin
        if (rst) begin
            chk("valid", 256'(dout_valid), 256'(m_slices > 0));
            chk("level", 256'(fifo_level), 256'((m_slices + N - 1) / N));
            chk("ovf",   256'(ovf_cnt),    256'(m_ovf));
            chk("rep",   256'(rep_fail),   256'(m_rep));
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dout: got %0h want nothing (no slice expected) at %0t", dout, $time);
                end else begin
                    logic [OUT_W-1:0] e;
                    e = exp_q.pop_front();
                    chk("dout", 256'(dout), 256'(e));
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [255:0] w, input logic r);
        rnd_valid  = v;
        rnd_in     = w;
        dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (DEPTH * N + 2) cyc(1'b0, '0, 1'b1);
    endtask

    logic [255:0] w, a, b, c, d, w6;
    logic [255:0] pool [4];

    initial begin
        rst        = 1'b0;
        rnd_in     = '0;
        rnd_valid  = 1'b0;
        dout_ready = 1'b0;
        #1;
        chk("rst_valid", 256'(dout_valid), 256'(0));
        chk("rst_level", 256'(fifo_level), 256'(0));
        chk("rst_ovf",   256'(ovf_cnt),    256'(0));
        chk("rst_rep",   256'(rep_fail),   256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // T1: single word, slices 1..8 back to back
        for (int k = 0; k < N; k++) w[k*32 +: 32] = 32'(k + 1);
        cyc(1'b1, w, 1'b1);
        chk("t1_first", 256'(dout), 256'(1));
        repeat (N + 2) cyc(1'b0, '0, 1'b1);
        chk("t1_done", 256'(dout_valid), 256'(0));

        // T2: six words into a depth-4 FIFO with no consumer
        for (int i = 0; i < 6; i++) cyc(1'b1, rnd_word(), 1'b0);
        chk("t2_level", 256'(fifo_level), 256'(4));
        chk("t2_ovf",   256'(ovf_cnt),    256'(2));
        drain();

        // T3: A, A, B
        a = rnd_word();
        b = rnd_word();
        cyc(1'b1, a, 1'b0);
        cyc(1'b1, a, 1'b0);
        chk("t3_rep", 256'(rep_fail), 256'(1));
        cyc(1'b1, b, 1'b0);
        chk("t3_level", 256'(fifo_level), 256'(2));
        drain();

        // T4: final-slice pop of a full FIFO coincides with a new word
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, rnd_word(), 1'b0);
        repeat (N - 1) cyc(1'b0, '0, 1'b1);
        c = rnd_word();
        cyc(1'b1, c, 1'b1);
        chk("t4_level", 256'(fifo_level), 256'(3));
        chk("t4_ovf",   256'(ovf_cnt),    256'(3));
        drain();

        // T5: level 1, final slice pops while D is pushed
        cyc(1'b1, rnd_word(), 1'b0);
        repeat (N - 1) cyc(1'b0, '0, 1'b1);
        d = rnd_word();
        cyc(1'b1, d, 1'b1);
        chk("t5_level", 256'(fifo_level), 256'(1));
        chk("t5_dout",  256'(dout),       256'(d[31:0]));
        drain();

        // T6: asynchronous reset mid-word, then re-push of the same word
        w6 = rnd_word();
        cyc(1'b1, w6, 1'b0);
        cyc(1'b1, w6, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1);
        dout_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", 256'(dout_valid), 256'(0));
        chk("t6_level", 256'(fifo_level), 256'(0));
        chk("t6_ovf",   256'(ovf_cnt),    256'(0));
        chk("t6_rep",   256'(rep_fail),   256'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, w6, 1'b0);
        chk("t6_norep",  256'(rep_fail),   256'(0));
        chk("t6_accept", 256'(fifo_level), 256'(1));
        drain();

        // Random traffic with a small pool so repeats actually occur
        for (int i = 0; i < 4; i++) pool[i] = rnd_word();
        for (int i = 0; i < 600; i++) begin
            logic v, r;
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) w = pool[$urandom_range(0, 3)];
            else w = rnd_word();
            cyc(v, w, r);
        end
        drain();
        chk("end_empty", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
